pinky_issue_ctl: RTL and testbench
==================================

Name: pinky_issue_ctl

Overview:
Scoreboard-based issue/interlock controller for the pipelined PinKY core. It sits between instruction fetch (stage 1) and register read (stage 2) and decides each cycle whether the fetched word issues, stalls, or is annulled. It replaces ad hoc freeze logic with explicit per-register pending bits, Z-flag tracking, PRE-prefix pairing, store/load ordering, jump redirect and halt drain.

Parameters:
NREGS, 16, number of architectural registers; scoreboard width
PCREG, 15, register index treated as PC; a write to it is a jump
STW, 2, width of the in-flight store counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_valid  input  1  fetch_ir holds a valid instruction word
fetch_ir  input  16  fetched instruction (Opcode[15:11], CC[10:9], isReg[8], Dest[7:4], Op2[3:0])
issue_ready  output  1  combinational; fetch word consumed this edge when fetch_valid&&issue_ready
issue_valid  output  1  registered; issue_ir is a real instruction (0 = bubble)
issue_ir  output  16  registered issued word; 16'h8000 when bubble
pre_active  output  1  registered; a PRE was issued and awaits its consumer
wb_valid  input  1  writeback stage retires an instruction this cycle
wb_dest  input  4  Dest of retiring instruction
wb_regwrite  input  1  retiring instruction wrote wb_dest
wb_setz  input  1  retiring instruction updated Z (CC==S)
wb_store  input  1  retiring instruction was str
zflag  input  1  architectural Z flag
flush  output  1  registered one-cycle pulse: fetch must discard held word and refetch from new PC
halt  output  1  registered; high in HALT state
busy_mask  output  NREGS  registered pending-write bits
stall_count  output  16  registered count of stall cycles

Behaviour:
- Reset (sync, high): busy_mask=0, zpend=0, st_cnt=0, pre_active=0, issue_valid=0, issue_ir=16'h8000, flush=0, halt=0, stall_count=0, state=RUN. issue_ready=0 while reset high.
- Decode: PRE = ir[15:14]==2'b11; sources = Dest always, Op2 if isReg; writes Dest unless opcode is str or sys; jump = writes Dest==PCREG.
- States: RUN, JWAIT, DRAIN, HALT.
- RUN, PRE word: always issues (no hazard check); sets pre_active.
- RUN, non-PRE hazard (any true -> issue_ready=0, bubble issued, stall_count+1 saturating at 16'hFFFF):
  - busy_mask[Dest] or (isReg && busy_mask[Op2]) (RAW/WAW)
  - zpend && CC in {EQ,NE}
  - opcode ldr && st_cnt!=0
  - st_cnt at max && opcode str
- Hazard checks use registered state only; a writeback in the same cycle clears its bit at that edge, so the waiter issues next cycle (one-cycle penalty, no bypass).
- RUN, no hazard: CC EQ with zflag=0, or NE with zflag=1 -> word consumed, annulled (issue_valid=0), pre_active cleared. Otherwise issued: issue_valid=1, issue_ir=fetch_ir, set busy_mask[Dest] if it writes, zpend=1 if CC==S, st_cnt+1 if str, pre_active cleared.
- Jump issued -> JWAIT: issue_ready=0, bubbles, until wb_valid&&wb_dest==PCREG&&wb_regwrite; then flush=1 for one cycle, back to RUN (that cycle issue_ready=0).
- sys issued -> DRAIN: issue_ready=0 until busy_mask==0, zpend=0, st_cnt=0; then HALT. HALT: halt=1, issue_ready=0, held until reset.
- Writeback (any state): wb_regwrite clears busy_mask[wb_dest]; wb_setz clears zpend; wb_store decrements st_cnt. Set at issue and clear at writeback of different registers on the same edge both take effect.
- pre_active persists across stalls; a PRE following a PRE overwrites (pre_active stays 1).
- fetch_valid=0 in RUN: bubble, stall_count unchanged.
- Reset mid-JWAIT/DRAIN: immediate return to reset values; no flush pulse.

Test Plan:
- add r1,r2 (isReg) then add r3,r1: second stalls until wb_dest=1 retires, exactly one cycle after that edge it issues; stall_count equals bubble count.
- add r2 with CC=S, then EQ mov r4: stalls while zpend; after wb_setz with zflag=0, mov annulled (issue_valid=0), busy_mask[4]=0.
- mov r15,#5: JWAIT bubbles; wb_dest=15 retires -> flush=1 one cycle, next cycle issue_ready=1.
- PRE 12'h0AB then mov r3 stalled on busy r3: pre_active stays 1 through stall, clears on mov issue.
- str r1 then ldr r2: ldr stalls until wb_store; st_cnt 1->0; then issues.
- sys with r5 pending: DRAIN until wb_dest=5, then halt=1; reset high one cycle in DRAIN -> halt=0, busy_mask=0, state RUN.

Source files
------------

// File: rtl/pinky_issue_ctl.sv
// PinKY issue/interlock controller: scoreboard-based issue, stall or annul
// of the fetched word, with jump redirect and halt drain.
// Opcode map: add=5'h00 mov=5'h01 ldr=5'h08 str=5'h09 sys=5'h17, 2'b11xxx=PRE.
// CC map: 00=always 01=EQ 10=NE 11=S (set Z).
module pinky_issue_ctl #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned PCREG = 15,
  parameter int unsigned STW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [15:0]      fetch_ir,
  output logic             issue_ready,
  output logic             issue_valid,
  output logic [15:0]      issue_ir,
  output logic             pre_active,
  input  logic             wb_valid,
  input  logic [3:0]       wb_dest,
  input  logic             wb_regwrite,
  input  logic             wb_setz,
  input  logic             wb_store,
  input  logic             zflag,
  output logic             flush,
  output logic             halt,
  output logic [NREGS-1:0] busy_mask,
  output logic [15:0]      stall_count
);

  localparam logic [4:0]     OP_LDR = 5'h08;
  localparam logic [4:0]     OP_STR = 5'h09;
  localparam logic [4:0]     OP_SYS = 5'h17;
  localparam logic [1:0]     CC_EQ  = 2'b01;
  localparam logic [1:0]     CC_NE  = 2'b10;
  localparam logic [1:0]     CC_S   = 2'b11;
  localparam logic [15:0]    BUBBLE = 16'h8000;
  localparam logic [3:0]     PC_IDX = 4'(PCREG);
  localparam logic [STW-1:0] ST_MAX = '1;

  typedef enum logic [1:0] {S_RUN, S_JWAIT, S_DRAIN, S_HALT} state_t;

  state_t           r_state, w_state_n;
  logic [NREGS-1:0] r_busy, w_busy_n;
  logic             r_zpend, w_zpend_n;
  logic [STW-1:0]   r_st_cnt, w_st_n;
  logic             r_pre_active, w_pre_n;
  logic             r_issue_valid, w_iv_n;
  logic [15:0]      r_issue_ir, w_ir_n;
  logic             r_flush, w_flush_n;
  logic             r_halt, w_halt_n;
  logic [15:0]      r_stall_count, w_stall_n;

  logic             w_issue_ready;
  logic             w_set_busy, w_set_z, w_st_inc, w_st_dec;

  // Field decode of the fetched word
  logic [4:0] w_op;
  logic [1:0] w_cc;
  logic       w_isreg;
  logic [3:0] w_dest, w_op2;
  logic       w_is_pre, w_is_str, w_is_ldr, w_is_sys, w_writes, w_jump;
  logic       w_hazard, w_annul;

  assign w_op     = fetch_ir[15:11];
  assign w_cc     = fetch_ir[10:9];
  assign w_isreg  = fetch_ir[8];
  assign w_dest   = fetch_ir[7:4];
  assign w_op2    = fetch_ir[3:0];
  assign w_is_pre = (fetch_ir[15:14] == 2'b11);
  assign w_is_str = (w_op == OP_STR);
  assign w_is_ldr = (w_op == OP_LDR);
  assign w_is_sys = (w_op == OP_SYS);
  assign w_writes = !(w_is_str || w_is_sys);
  assign w_jump   = w_writes && (w_dest == PC_IDX);

  // Interlocks evaluated against registered scoreboard state only
  assign w_hazard = r_busy[w_dest]
                 || (w_isreg && r_busy[w_op2])
                 || (r_zpend && ((w_cc == CC_EQ) || (w_cc == CC_NE)))
                 || (w_is_ldr && (r_st_cnt != '0))
                 || (w_is_str && (r_st_cnt == ST_MAX));
  assign w_annul  = ((w_cc == CC_EQ) && !zflag) || ((w_cc == CC_NE) && zflag);

  assign w_st_dec = wb_valid && wb_store;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_busy        <= '0;
      r_zpend       <= 1'b0;
      r_st_cnt      <= '0;
      r_pre_active  <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_ir    <= BUBBLE;
      r_flush       <= 1'b0;
      r_halt        <= 1'b0;
      r_stall_count <= 16'h0000;
    end else begin
      r_state       <= w_state_n;
      r_busy        <= w_busy_n;
      r_zpend       <= w_zpend_n;
      r_st_cnt      <= w_st_n;
      r_pre_active  <= w_pre_n;
      r_issue_valid <= w_iv_n;
      r_issue_ir    <= w_ir_n;
      r_flush       <= w_flush_n;
      r_halt        <= w_halt_n;
      r_stall_count <= w_stall_n;
    end
  end

  // Next-state, issue decision and scoreboard update
  always_comb begin
    w_state_n     = r_state;
    w_busy_n      = r_busy;
    w_zpend_n     = r_zpend;
    w_st_n        = r_st_cnt;
    w_pre_n       = r_pre_active;
    w_iv_n        = 1'b0;
    w_ir_n        = BUBBLE;
    w_flush_n     = 1'b0;
    w_halt_n      = 1'b0;
    w_stall_n     = r_stall_count;
    w_issue_ready = 1'b0;
    w_set_busy    = 1'b0;
    w_set_z       = 1'b0;
    w_st_inc      = 1'b0;

    case (r_state)
      S_RUN: begin
        // The cycle carrying the flush pulse never consumes a word
        if (!r_flush) begin
          w_issue_ready = w_is_pre || !w_hazard;
          if (fetch_valid) begin
            if (w_is_pre) begin
              w_iv_n  = 1'b1;
              w_ir_n  = fetch_ir;
              w_pre_n = 1'b1;
            end else if (w_hazard) begin
              if (r_stall_count != 16'hFFFF) w_stall_n = r_stall_count + 16'd1;
            end else if (w_annul) begin
              w_pre_n = 1'b0;
            end else begin
              w_iv_n     = 1'b1;
              w_ir_n     = fetch_ir;
              w_pre_n    = 1'b0;
              w_set_busy = w_writes;
              w_set_z    = (w_cc == CC_S);
              w_st_inc   = w_is_str;
              if (w_jump)        w_state_n = S_JWAIT;
              else if (w_is_sys) w_state_n = S_DRAIN;
            end
          end
        end
      end
      S_JWAIT: begin
        if (wb_valid && wb_regwrite && (wb_dest == PC_IDX)) begin
          w_state_n = S_RUN;
          w_flush_n = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((r_busy == '0) && !r_zpend && (r_st_cnt == '0)) w_state_n = S_HALT;
      end
      S_HALT: begin
        w_state_n = S_HALT;
      end
      default: w_state_n = S_RUN;
    endcase

    w_halt_n = (w_state_n == S_HALT);

    // Writeback clear first, then issue set, so both land on one edge
    if (wb_valid && wb_regwrite) w_busy_n[wb_dest] = 1'b0;
    if (w_set_busy)              w_busy_n[w_dest]  = 1'b1;
    w_zpend_n = (r_zpend && !(wb_valid && wb_setz)) || w_set_z;
    if (w_st_inc && !w_st_dec)
      w_st_n = r_st_cnt + STW'(1);
    else if (!w_st_inc && w_st_dec && (r_st_cnt != '0))
      w_st_n = r_st_cnt - STW'(1);
  end

  assign issue_ready = w_issue_ready && !reset;
  assign issue_valid = r_issue_valid;
  assign issue_ir    = r_issue_ir;
  assign pre_active  = r_pre_active;
  assign flush       = r_flush;
  assign halt        = r_halt;
  assign busy_mask   = r_busy;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pinky_issue_ctl.sv
// Directed bench for pinky_issue_ctl with hand-computed expectations.
module tb_pinky_issue_ctl;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_MOV = 5'h01;
  localparam logic [4:0] OP_LDR = 5'h08;
  localparam logic [4:0] OP_STR = 5'h09;
  localparam logic [4:0] OP_SYS = 5'h17;
  localparam logic [1:0] AL = 2'b00;
  localparam logic [1:0] EQ = 2'b01;
  localparam logic [1:0] NE = 2'b10;
  localparam logic [1:0] CS = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [15:0] fetch_ir;
  logic        issue_ready, issue_valid, pre_active, flush, halt;
  logic [15:0] issue_ir, busy_mask, stall_count;
  logic        wb_valid, wb_regwrite, wb_setz, wb_store, zflag;
  logic [3:0]  wb_dest;

  int n_chk  = 0;
  int n_pass = 0;

  pinky_issue_ctl dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ir(fetch_ir),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_ir(issue_ir),
    .pre_active(pre_active), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_regwrite(wb_regwrite), .wb_setz(wb_setz), .wb_store(wb_store),
    .zflag(zflag), .flush(flush), .halt(halt), .busy_mask(busy_mask),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] cc,
                                     input logic isr, input logic [3:0] d,
                                     input logic [3:0] s);
    return {op, cc, isr, d, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic [3:0] d, input logic rw, input logic sz, input logic st);
    wb_valid = 1'b1; wb_dest = d; wb_regwrite = rw; wb_setz = sz; wb_store = st;
  endtask

  task automatic wb_clr();
    wb_valid = 1'b0; wb_dest = 4'h0; wb_regwrite = 1'b0; wb_setz = 1'b0; wb_store = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; fetch_valid = 1'b1; fetch_ir = mk(OP_ADD, AL, 1'b1, 4'd1, 4'd2);
    zflag = 1'b0; wb_clr();
    tick(); tick();
    // reset state
    chk("rst_ready", issue_ready, 0);
    chk("rst_iv", issue_valid, 0);
    chk("rst_ir", issue_ir, 16'h8000);
    chk("rst_busy", busy_mask, 0);
    chk("rst_halt", halt, 0);
    chk("rst_flush", flush, 0);
    chk("rst_pre", pre_active, 0);
    chk("rst_stall", stall_count, 0);

    // RAW: add r1,r2 then add r3,r1
    reset = 1'b0; #1;
    chk("raw_ready_a", issue_ready, 1);
    tick();
    chk("raw_iv_a", issue_valid, 1);
    chk("raw_ir_a", issue_ir, mk(OP_ADD, AL, 1'b1, 4'd1, 4'd2));
    chk("raw_busy_a", busy_mask, 16'h0002);
    fetch_ir = mk(OP_ADD, AL, 1'b1, 4'd3, 4'd1); #1;
    chk("raw_ready_stall", issue_ready, 0);
    tick();
    chk("raw_iv_bub", issue_valid, 0);
    chk("raw_ir_bub", issue_ir, 16'h8000);
    chk("raw_stall1", stall_count, 1);
    tick();
    chk("raw_stall2", stall_count, 2);
    wb_set(4'd1, 1'b1, 1'b0, 1'b0); #1;
    chk("raw_ready_wbcyc", issue_ready, 0);
    tick();
    chk("raw_stall3", stall_count, 3);
    chk("raw_busy_clr", busy_mask, 0);
    wb_clr(); #1;
    chk("raw_ready_b", issue_ready, 1);
    tick();
    chk("raw_iv_b", issue_valid, 1);
    chk("raw_ir_b", issue_ir, mk(OP_ADD, AL, 1'b1, 4'd3, 4'd1));
    chk("raw_busy_b", busy_mask, 16'h0008);
    chk("raw_stall_b", stall_count, 3);
    fetch_valid = 1'b0; wb_set(4'd3, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();
    chk("idle_busy", busy_mask, 0);
    chk("idle_iv", issue_valid, 0);
    chk("idle_stall", stall_count, 3);

    // Z tracking: add r2 S, then EQ mov r4 annulled
    fetch_valid = 1'b1; fetch_ir = mk(OP_ADD, CS, 1'b0, 4'd2, 4'd0);
    tick();
    chk("z_iv_a", issue_valid, 1);
    chk("z_busy_a", busy_mask, 16'h0004);
    fetch_ir = mk(OP_MOV, EQ, 1'b0, 4'd4, 4'd0); #1;
    chk("z_ready_stall", issue_ready, 0);
    tick();
    chk("z_stall1", stall_count, 4);
    wb_set(4'd2, 1'b1, 1'b1, 1'b0); zflag = 1'b0;
    tick(); wb_clr();
    chk("z_stall2", stall_count, 5);
    #1 chk("z_ready_b", issue_ready, 1);
    tick();
    chk("z_annul_iv", issue_valid, 0);
    chk("z_annul_ir", issue_ir, 16'h8000);
    chk("z_annul_busy", busy_mask, 0);
    chk("z_annul_stall", stall_count, 5);
    fetch_ir = mk(OP_MOV, NE, 1'b0, 4'd4, 4'd0);
    tick();
    chk("z_ne_iv", issue_valid, 1);
    chk("z_ne_busy", busy_mask, 16'h0010);
    fetch_valid = 1'b0; wb_set(4'd4, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();

    // Jump: mov r15,#5
    fetch_valid = 1'b1; fetch_ir = mk(OP_MOV, AL, 1'b0, 4'd15, 4'd5);
    tick();
    chk("j_iv", issue_valid, 1);
    chk("j_busy", busy_mask, 16'h8000);
    fetch_ir = mk(OP_ADD, AL, 1'b0, 4'd6, 4'd0); #1;
    chk("j_ready_wait", issue_ready, 0);
    tick();
    chk("j_bub", issue_valid, 0);
    chk("j_stall", stall_count, 5);
    chk("j_noflush", flush, 0);
    wb_set(4'd15, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();
    chk("j_flush", flush, 1);
    chk("j_busy_clr", busy_mask, 0);
    #1 chk("j_ready_flushcyc", issue_ready, 0);
    tick();
    chk("j_flush_off", flush, 0);
    chk("j_flushcyc_iv", issue_valid, 0);
    chk("j_ready_after", issue_ready, 1);
    fetch_valid = 1'b0;

    // PRE across a stall
    fetch_valid = 1'b1; fetch_ir = mk(OP_ADD, AL, 1'b0, 4'd3, 4'd0);
    tick();
    chk("p_busy", busy_mask, 16'h0008);
    fetch_ir = 16'hC0AB; #1;
    chk("p_ready_pre", issue_ready, 1);
    tick();
    chk("p_iv", issue_valid, 1);
    chk("p_ir", issue_ir, 16'hC0AB);
    chk("p_active", pre_active, 1);
    fetch_ir = mk(OP_MOV, AL, 1'b0, 4'd3, 4'd0); #1;
    chk("p_ready_stall", issue_ready, 0);
    tick();
    chk("p_active_stall", pre_active, 1);
    chk("p_stall1", stall_count, 6);
    wb_set(4'd3, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();
    chk("p_stall2", stall_count, 7);
    chk("p_active_stall2", pre_active, 1);
    tick();
    chk("p_mov_iv", issue_valid, 1);
    chk("p_active_clr", pre_active, 0);
    chk("p_mov_busy", busy_mask, 16'h0008);
    fetch_valid = 1'b0; wb_set(4'd3, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();

    // Store/load ordering
    fetch_valid = 1'b1; fetch_ir = mk(OP_STR, AL, 1'b0, 4'd1, 4'd0);
    tick();
    chk("s_iv", issue_valid, 1);
    chk("s_busy", busy_mask, 0);
    fetch_ir = mk(OP_LDR, AL, 1'b0, 4'd2, 4'd0); #1;
    chk("s_ldr_stall", issue_ready, 0);
    tick();
    chk("s_stall1", stall_count, 8);
    wb_set(4'd0, 1'b0, 1'b0, 1'b1);
    tick(); wb_clr();
    chk("s_stall2", stall_count, 9);
    #1 chk("s_ldr_ready", issue_ready, 1);
    tick();
    chk("s_ldr_iv", issue_valid, 1);
    chk("s_ldr_busy", busy_mask, 16'h0004);
    fetch_valid = 1'b0; wb_set(4'd2, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();
    // Store counter full at 3
    fetch_valid = 1'b1; fetch_ir = mk(OP_STR, AL, 1'b0, 4'd1, 4'd0);
    tick(); tick(); tick();
    chk("s_full_ready", issue_ready, 0);
    tick();
    chk("s_full_stall", stall_count, 10);
    wb_set(4'd0, 1'b0, 1'b0, 1'b1);
    tick(); wb_clr();
    chk("s_full_stall2", stall_count, 11);
    #1 chk("s_full_ready2", issue_ready, 1);
    tick();
    chk("s_full_iv", issue_valid, 1);
    fetch_valid = 1'b0; wb_set(4'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick(); wb_clr();

    // sys drains then halts
    fetch_valid = 1'b1; fetch_ir = mk(OP_ADD, AL, 1'b0, 4'd5, 4'd0);
    tick();
    chk("h_busy", busy_mask, 16'h0020);
    fetch_ir = mk(OP_SYS, AL, 1'b0, 4'd0, 4'd0); #1;
    chk("h_sys_ready", issue_ready, 1);
    tick();
    chk("h_sys_iv", issue_valid, 1);
    fetch_ir = mk(OP_ADD, AL, 1'b0, 4'd6, 4'd0); #1;
    chk("h_drain_ready", issue_ready, 0);
    tick();
    chk("h_drain_halt", halt, 0);
    chk("h_drain_iv", issue_valid, 0);
    wb_set(4'd5, 1'b1, 1'b0, 1'b0);
    tick(); wb_clr();
    chk("h_busy_clr", busy_mask, 0);
    chk("h_halt_pre", halt, 0);
    tick();
    chk("h_halt", halt, 1);
    chk("h_halt_ready", issue_ready, 0);
    tick();
    chk("h_halt_hold", halt, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("h_rst_halt", halt, 0);

    // Reset while draining
    fetch_ir = mk(OP_ADD, AL, 1'b0, 4'd5, 4'd0);
    tick();
    fetch_ir = mk(OP_SYS, AL, 1'b0, 4'd0, 4'd0);
    tick();
    chk("d_busy", busy_mask, 16'h0020);
    fetch_ir = mk(OP_ADD, AL, 1'b0, 4'd6, 4'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("d_halt", halt, 0);
    chk("d_busy_rst", busy_mask, 0);
    chk("d_flush", flush, 0);
    chk("d_iv", issue_valid, 0);
    chk("d_stall", stall_count, 0);
    #1 chk("d_ready_run", issue_ready, 1);
    fetch_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
